// File: rtl/cpu_pkg.sv
// Shared fetch/decode definitions: widths, reset PC, NOP, fetch states and
// the opcode values the control decoder keys on.
package cpu_pkg;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
endpackage

// File: rtl/cpu_fetch_if.sv
// Instruction-memory channel: valid/ready request, single-cycle-pulse response.
interface cpu_fetch_if #(parameter int XLEN = cpu_pkg::XLEN);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (output imem_req_valid, imem_addr,
                  input  imem_req_ready, imem_rsp_valid, imem_rsp_data);
  modport slave  (input  imem_req_valid, imem_addr,
                  output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

// File: rtl/cpu_pc_reg.sv
// Program counter: reset load, redirect (word-aligned), +4 on a kept fetch.
module cpu_pc_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redir,
  input  logic            inc,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);
  always_ff @(posedge clk) begin
    if (!rst_n)     pc <= RESET_PC;
    else if (redir) pc <= target & ~XLEN'(3);
    else if (inc)   pc <= pc + XLEN'(4);
  end
endmodule

// File: rtl/cpu_fetch.sv
// Fetch stage: one outstanding imem request, registered instruction/PC to
// decode, redirect squashes in-flight or held work.
module cpu_fetch #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(cpu_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  cpu_fetch_if.master     imem,
  output logic            if_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      if_opcode,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  import cpu_pkg::*;

  fetch_state_e    state;
  logic            discard;
  logic            req_valid;
  logic [XLEN-1:0] pc;
  logic            accept, redir, inc;

  assign accept = req_valid && imem.imem_req_ready;
  assign redir  = redirect_valid && (state != IDLE);
  assign inc    = (state == WAIT) && imem.imem_rsp_valid && !discard && !redirect_valid;

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_addr      = pc;
  assign if_opcode           = if_instr[6:0];

  cpu_pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .redir  (redir),
    .inc    (inc),
    .target (redirect_pc),
    .pc     (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      discard   <= 1'b0;
      req_valid <= 1'b0;
      if_valid  <= 1'b0;
      if_instr  <= XLEN'(NOP);
      if_pc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          state     <= REQ;
          req_valid <= 1'b1;
        end
        REQ: begin
          if (redirect_valid) if_valid <= 1'b0;
          // a request accepted alongside a redirect is already stale
          if (accept) begin
            state     <= WAIT;
            req_valid <= 1'b0;
            if (redirect_valid) discard <= 1'b1;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            if_valid <= 1'b0;
            if (imem.imem_rsp_valid) begin
              discard   <= 1'b0;
              state     <= REQ;
              req_valid <= 1'b1;
            end else begin
              discard <= 1'b1;
            end
          end else if (imem.imem_rsp_valid) begin
            if (discard) begin
              discard   <= 1'b0;
              state     <= REQ;
              req_valid <= 1'b1;
            end else begin
              if_instr <= imem.imem_rsp_data;
              if_pc    <= pc;
              if_valid <= 1'b1;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          // redirect wins over id_ready: decode must not commit this cycle
          if (redirect_valid || id_ready) begin
            if_valid  <= 1'b0;
            state     <= REQ;
            req_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/cpu_fetch.md
Name: cpu_fetch

Overview:
Instruction fetch stage sitting directly upstream of the control decoder. It holds the PC and issues one word request at a time to instruction memory over a valid/ready request channel and a valid response channel. It presents the fetched instruction, its PC and its opcode field to decode with a valid/ready handshake. It accepts a branch/jump redirect from execute.

Parameters:
XLEN, 32, width of PC and instruction word
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request this cycle
imem_addr  out  XLEN  byte address of request, word aligned
imem_rsp_valid  in  1  response data valid (one cycle pulse)
imem_rsp_data  in  XLEN  instruction word
if_valid  out  1  if_instr/if_pc valid to decode
id_ready  in  1  decode consumes instruction this cycle
if_instr  out  XLEN  fetched instruction
if_pc  out  XLEN  address of if_instr
if_opcode  out  7  if_instr[6:0], feeds control decoder
redirect_valid  in  1  branch taken / jump from execute
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored, treated as 0

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, pc=RESET_PC, discard=0, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0, imem_req_valid=0. if_opcode always equals if_instr[6:0].
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: one cycle after reset release -> REQ. imem_rsp_valid ignored.
- REQ: imem_req_valid=1, imem_addr=pc (combinational from pc). imem samples the address only on accept, so address may change while unaccepted. Accept (valid&&ready) -> WAIT.
- WAIT: imem_req_valid=0. On imem_rsp_valid:
  - if discard=1: drop data, clear discard -> REQ.
  - else: register if_instr=rsp_data, if_pc=pc, if_valid=1, pc<=pc+4 -> HOLD.
- HOLD: if_valid=1, outputs stable until id_ready=1; on id_ready: if_valid<=0 -> REQ.
- One outstanding request max; no request is issued in WAIT or HOLD.
- Latency: request accepted cycle N, response earliest N+1, if_valid at N+2; back-to-back throughput is one instruction per 3 cycles with single-cycle imem.
- Redirect (highest priority, any state except IDLE): pc<={redirect_pc[XLEN-1:2],2'b00}; if_valid<=0.
  - In REQ without accept: next state REQ with new address.
  - In REQ with accept in the same cycle, or in WAIT without response: discard<=1, state WAIT (stale response dropped).
  - In WAIT with response in the same cycle: response dropped, discard stays 0 -> REQ.
  - In HOLD: held instruction squashed even if id_ready=1 the same cycle (decode must not commit on a redirect cycle) -> REQ.
- PC arithmetic modulo 2^XLEN: pc 32'hFFFF_FFFC + 4 wraps to 0.
- Reset mid-operation: all state cleared as above. imem shares rst_n, so no pre-reset response arrives afterwards.

Decomposition:
- Package cpu_pkg:
  - XLEN, RESET_PC
  - NOP constant 32'h0000_0013
  - fetch state enum {IDLE, REQ, WAIT, HOLD}
  - opcode constants shared with control decoder: OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_RTYPE 7'b0110011, OP_BRANCH 7'b1100011, OP_JAL 7'b1101111
- One sub-module, cpu_pc_reg: PC register with reset load, +4 increment and redirect mux. FSM and output registers stay in cpu_fetch.

Test Plan:
- Reset release, imem always ready, 1-cycle response returning 32'h00A00093 -> imem_addr 0 then 4 then 8; if_pc 0,4,8; if_opcode 7'b0010011; if_valid two cycles after each accept.
- id_ready held 0 for 5 cycles in HOLD -> if_instr/if_pc stable, imem_req_valid=0 throughout; then id_ready=1 -> next request address pc+4.
- imem_req_ready=0 for 3 cycles, redirect to 32'h0000_0103 on cycle 2 -> imem_addr becomes 32'h0000_0100, single accept, if_pc=32'h100.
- Redirect to 32'h200 while in WAIT, stale response 32'hDEADBEEF arrives later -> stale data never on if_instr; next fetch at 32'h200.
- Redirect in HOLD with id_ready=1 same cycle -> if_valid=0 next cycle, next request at redirect target.
- RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0000_0000; rst_n low while in WAIT -> IDLE, if_valid=0, refetch from RESET_PC.
